// File: rtl/rv3n_csr_issue_if.sv
// Request/ack bundle between the CSR issue block and the CSR unit.
// The issuer drives the request side; the CSR unit drives ack/busy.
interface rv3n_csr_issue_if #(
    parameter int XLEN = 32
);
    logic            func_csr_req_valid;
    logic [7:0]      func_csr_req_para;
    logic [12:0]     func_csr_req_imm;
    logic [XLEN-1:0] func_csr_req_pc;
    logic [XLEN-1:0] func_csr_req_operand0;
    logic [XLEN-1:0] func_csr_req_operand1;
    logic            func_csr_ack_valid;
    logic [XLEN-1:0] func_csr_ack_data;
    logic            func_csr_ack_busy;

    modport master (
        output func_csr_req_valid, func_csr_req_para, func_csr_req_imm,
               func_csr_req_pc, func_csr_req_operand0, func_csr_req_operand1,
        input  func_csr_ack_valid, func_csr_ack_data, func_csr_ack_busy
    );

    modport slave (
        input  func_csr_req_valid, func_csr_req_para, func_csr_req_imm,
               func_csr_req_pc, func_csr_req_operand0, func_csr_req_operand1,
        output func_csr_ack_valid, func_csr_ack_data, func_csr_ack_busy
    );
endinterface

// File: rtl/rv3n_csr_issue.sv
// CSR/system instruction issue: holds one instruction from execute, issues a
// single-cycle request to the CSR unit once it is not busy, waits for the ack
// (bounded by TIMEOUT cycles) and writes the old CSR value back to rd.
module rv3n_csr_issue #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr_para,
    input  logic [12:0]       instr_imm,
    input  logic [XLEN-1:0]   instr_pc,
    input  logic [XLEN-1:0]   instr_operand0,
    input  logic [XLEN-1:0]   instr_operand1,
    rv3n_csr_issue_if.master  csr,
    input  logic              stage_id_clear,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              csr_pending,
    output logic              timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [7:0]      para_q;
    logic [12:0]     imm_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] op0_q;
    logic [XLEN-1:0] op1_q;
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            terr_q;
    logic            wb_en_d;

    // Only real CSR ops with a non-zero rd write the register file.
    assign wb_en_d = para_q[4] & ~para_q[5] & (op1_q[11:7] != 5'd0);
    // Saturating wait counter increment.
    assign cnt_d   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    // Request strobe is combinational so it fires in the first non-busy HOLD
    // cycle; a flush in the same cycle wins over the issue.
    assign csr.func_csr_req_valid    = (state_q == S_HOLD) & ~csr.func_csr_ack_busy & ~stage_id_clear;
    assign csr.func_csr_req_para     = para_q;
    assign csr.func_csr_req_imm      = imm_q;
    assign csr.func_csr_req_pc       = pc_q;
    assign csr.func_csr_req_operand0 = op0_q;
    assign csr.func_csr_req_operand1 = op1_q;

    assign instr_ready = (state_q == S_IDLE);
    assign csr_pending = (state_q != S_IDLE);
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign timeout_err = terr_q;

    // Issue FSM: capture, issue, wait for ack or timeout, register writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            para_q     <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            op0_q      <= '0;
            op1_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            terr_q     <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (instr_valid && !stage_id_clear) begin
                        para_q  <= instr_para;
                        imm_q   <= instr_imm;
                        pc_q    <= instr_pc;
                        op0_q   <= instr_operand0;
                        op1_q   <= instr_operand1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (stage_id_clear) begin
                        state_q <= S_IDLE;
                    end else if (!csr.func_csr_ack_busy) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Flush is ignored here: the request is already committed.
                    if (csr.func_csr_ack_valid) begin
                        state_q <= S_IDLE;
                        if (wb_en_d) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= op1_q[11:7];
                            wb_data_q  <= csr.func_csr_ack_data;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        terr_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv3n_csr_issue.sv
// Bench for rv3n_csr_issue: directed vector table, hand sequences for
// ecall/timeout/reset, then random traffic against a transaction-level model.
module tb_rv3n_csr_issue;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            instr_valid;
    logic            instr_ready;
    logic [7:0]      instr_para;
    logic [12:0]     instr_imm;
    logic [XLEN-1:0] instr_pc, instr_operand0, instr_operand1;
    logic            stage_id_clear;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            csr_pending;
    logic            timeout_err;

    rv3n_csr_issue_if #(.XLEN(XLEN)) csr_if ();

    rv3n_csr_issue #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_para(instr_para), .instr_imm(instr_imm), .instr_pc(instr_pc),
        .instr_operand0(instr_operand0), .instr_operand1(instr_operand1),
        .csr(csr_if),
        .stage_id_clear(stage_id_clear),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .csr_pending(csr_pending), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [7:0] p, input logic [12:0] im, input logic [31:0] pc,
                             input logic [31:0] o0, input logic [31:0] o1);
        instr_para = p; instr_imm = im; instr_pc = pc; instr_operand0 = o0; instr_operand1 = o1;
    endtask

    task automatic quiet();
        instr_valid = 1'b0; stage_id_clear = 1'b0;
        csr_if.func_csr_ack_valid = 1'b0; csr_if.func_csr_ack_busy = 1'b0;
        csr_if.func_csr_ack_data = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
        chk({tag, "_req"},   32'(csr_if.func_csr_req_valid), 32'd0);
        chk({tag, "_op1"},   csr_if.func_csr_req_operand1, 32'd0);
        chk({tag, "_para"},  32'(csr_if.func_csr_req_para), 32'd0);
        chk({tag, "_pend"},  32'(csr_pending), 32'd0);
        chk({tag, "_wb"},    32'(wb_valid), 32'd0);
        chk({tag, "_rd"},    32'(wb_rd), 32'd0);
        chk({tag, "_data"},  wb_data, 32'd0);
        chk({tag, "_terr"},  32'(timeout_err), 32'd0);
    endtask

    typedef struct {
        logic        v, clr, busy, ack;
        logic [31:0] ack_data;
        logic        e_ready, e_req, e_pend, e_wb;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic v, clr, busy, ack, input logic [31:0] ad,
                                input logic r, q, p, w, input logic [4:0] rd, input logic [31:0] d);
        vec_t t;
        t.v = v; t.clr = clr; t.busy = busy; t.ack = ack; t.ack_data = ad;
        t.e_ready = r; t.e_req = q; t.e_pend = p; t.e_wb = w; t.e_rd = rd; t.e_data = d;
        return t;
    endfunction

    // Transaction-level reference state.
    bit          m_held, m_out, m_terr, m_wb;
    int          m_waited;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [7:0]  h_para;
    logic [12:0] h_imm;
    logic [31:0] h_pc, h_op0, h_op1;

    task automatic model_reset();
        m_held = 0; m_out = 0; m_terr = 0; m_wb = 0; m_waited = 0;
        m_rd = '0; m_data = '0;
        h_para = '0; h_imm = '0; h_pc = '0; h_op0 = '0; h_op1 = '0;
    endtask

    task automatic model_step();
        m_wb = 0;
        if (m_out) begin
            if (csr_if.func_csr_ack_valid) begin
                m_out = 0;
                if (h_para[4] && !h_para[5] && h_op1[11:7] != 5'd0) begin
                    m_wb = 1; m_rd = h_op1[11:7]; m_data = csr_if.func_csr_ack_data;
                end
            end else begin
                m_waited++;
                if (m_waited >= TIMEOUT) begin
                    m_out = 0; m_terr = 1;
                end
            end
        end else if (m_held) begin
            if (stage_id_clear) m_held = 0;
            else if (!csr_if.func_csr_ack_busy) begin
                m_held = 0; m_out = 1; m_waited = 0;
            end
        end else if (instr_valid && !stage_id_clear) begin
            m_held = 1;
            h_para = instr_para; h_imm = instr_imm; h_pc = instr_pc;
            h_op0 = instr_operand0; h_op1 = instr_operand1;
        end
    endtask

    vec_t tbl[21];
    int   wb_cnt;

    initial begin
        // csrrw x5, mscratch sequence, then busy stall, flush in HOLD, flush in WAIT_ACK, stray ack.
        tbl[0]  = mk(1,0,0,0,32'h0,        1,0,0,0,5'd0,32'h0);
        tbl[1]  = mk(0,0,0,0,32'h0,        0,1,1,0,5'd0,32'h0);
        tbl[2]  = mk(0,0,0,0,32'h0,        0,0,1,0,5'd0,32'h0);
        tbl[3]  = mk(0,0,0,1,32'h0,        0,0,1,0,5'd0,32'h0);
        tbl[4]  = mk(1,0,1,0,32'h0,        1,0,0,1,5'd5,32'h0);
        tbl[5]  = mk(0,0,1,0,32'h0,        0,0,1,0,5'd5,32'h0);
        tbl[6]  = mk(0,0,1,0,32'h0,        0,0,1,0,5'd5,32'h0);
        tbl[7]  = mk(0,0,1,0,32'h0,        0,0,1,0,5'd5,32'h0);
        tbl[8]  = mk(0,0,0,0,32'h0,        0,1,1,0,5'd5,32'h0);
        tbl[9]  = mk(0,0,0,0,32'h0,        0,0,1,0,5'd5,32'h0);
        tbl[10] = mk(0,0,0,1,32'hDEADBEEF, 0,0,1,0,5'd5,32'h0);
        tbl[11] = mk(1,0,0,0,32'h0,        1,0,0,1,5'd5,32'hDEADBEEF);
        tbl[12] = mk(0,1,0,0,32'h0,        0,0,1,0,5'd5,32'hDEADBEEF);
        tbl[13] = mk(1,1,0,0,32'h0,        1,0,0,0,5'd5,32'hDEADBEEF);
        tbl[14] = mk(1,0,0,0,32'h0,        1,0,0,0,5'd5,32'hDEADBEEF);
        tbl[15] = mk(0,0,0,0,32'h0,        0,1,1,0,5'd5,32'hDEADBEEF);
        tbl[16] = mk(0,1,0,0,32'h0,        0,0,1,0,5'd5,32'hDEADBEEF);
        tbl[17] = mk(0,0,0,1,32'h12345678, 0,0,1,0,5'd5,32'hDEADBEEF);
        tbl[18] = mk(0,0,0,0,32'h0,        1,0,0,1,5'd5,32'h12345678);
        tbl[19] = mk(0,0,0,1,32'h55555555, 1,0,0,0,5'd5,32'h12345678);
        tbl[20] = mk(0,0,0,0,32'h0,        1,0,0,0,5'd5,32'h12345678);

        quiet();
        set_instr(8'h10, 13'h340, 32'h0000_0100, 32'hA5A5_0000, 32'h3402_92F3);
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        next_cyc();

        foreach (tbl[i]) begin
            instr_valid = tbl[i].v; stage_id_clear = tbl[i].clr;
            csr_if.func_csr_ack_busy = tbl[i].busy; csr_if.func_csr_ack_valid = tbl[i].ack;
            csr_if.func_csr_ack_data = tbl[i].ack_data;
            @(negedge clk);
            chk($sformatf("row%0d_ready", i), 32'(instr_ready), 32'(tbl[i].e_ready));
            chk($sformatf("row%0d_req", i),   32'(csr_if.func_csr_req_valid), 32'(tbl[i].e_req));
            chk($sformatf("row%0d_pend", i),  32'(csr_pending), 32'(tbl[i].e_pend));
            chk($sformatf("row%0d_wb", i),    32'(wb_valid), 32'(tbl[i].e_wb));
            chk($sformatf("row%0d_rd", i),    32'(wb_rd), 32'(tbl[i].e_rd));
            chk($sformatf("row%0d_data", i),  wb_data, tbl[i].e_data);
            chk($sformatf("row%0d_terr", i),  32'(timeout_err), 32'd0);
            if (tbl[i].e_req) begin
                chk($sformatf("row%0d_op1", i), csr_if.func_csr_req_operand1, 32'h3402_92F3);
                chk($sformatf("row%0d_op0", i), csr_if.func_csr_req_operand0, 32'hA5A5_0000);
            end
            next_cyc();
        end
        quiet();

        // ecall: request issued and acked, but never written back.
        set_instr(8'h20, 13'h0, 32'h0000_0200, 32'h0, 32'h0000_0073);
        instr_valid = 1'b1;
        next_cyc();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("ecall_req", 32'(csr_if.func_csr_req_valid), 32'd1);
        chk("ecall_para", 32'(csr_if.func_csr_req_para), 32'h20);
        next_cyc();
        csr_if.func_csr_ack_valid = 1'b1;
        next_cyc();
        csr_if.func_csr_ack_valid = 1'b0;
        wb_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wb_valid) wb_cnt++;
            next_cyc();
        end
        chk("ecall_wb_cnt", 32'(wb_cnt), 32'd0);
        chk("ecall_ready", 32'(instr_ready), 32'd1);

        // csrrs x0 with no ack: times out after TIMEOUT wait cycles.
        set_instr(8'h10, 13'h340, 32'h0000_0300, 32'h0, 32'h3400_2073);
        instr_valid = 1'b1;
        next_cyc();
        instr_valid = 1'b0;
        next_cyc();
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            chk($sformatf("to_pend%0d", k), 32'(csr_pending), 32'd1);
            chk($sformatf("to_terr%0d", k), 32'(timeout_err), 32'd0);
            next_cyc();
        end
        @(negedge clk);
        chk("to_terr_set", 32'(timeout_err), 32'd1);
        chk("to_ready", 32'(instr_ready), 32'd1);
        chk("to_wb", 32'(wb_valid), 32'd0);
        next_cyc();

        // Reset while waiting for ack, then a stray ack afterwards.
        set_instr(8'h10, 13'h340, 32'h0000_0400, 32'h1, 32'h3402_92F3);
        instr_valid = 1'b1;
        next_cyc();
        instr_valid = 1'b0;
        next_cyc();
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        next_cyc();
        csr_if.func_csr_ack_valid = 1'b1;
        csr_if.func_csr_ack_data = 32'hAAAA_AAAA;
        next_cyc();
        csr_if.func_csr_ack_valid = 1'b0;
        @(negedge clk);
        chk("stray_wb", 32'(wb_valid), 32'd0);
        chk("stray_ready", 32'(instr_ready), 32'd1);
        chk("stray_data", wb_data, 32'd0);
        next_cyc();

        // Random traffic against the reference model.
        rst = 1'b1;
        next_cyc();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        next_cyc();
        for (int n = 0; n < 2000; n++) begin
            instr_valid    = ($urandom_range(0, 1) == 1);
            stage_id_clear = ($urandom_range(0, 9) == 0);
            csr_if.func_csr_ack_busy  = ($urandom_range(0, 9) < 3);
            csr_if.func_csr_ack_valid = ($urandom_range(0, 3) == 0);
            csr_if.func_csr_ack_data  = $urandom;
            set_instr(8'($urandom), 13'($urandom), $urandom, $urandom,
                      {$urandom_range(0, 3) == 0 ? 20'h0 : 20'($urandom), 5'($urandom), 7'h73});
            @(negedge clk);
            chk("rnd_ready", 32'(instr_ready), 32'(!m_held && !m_out));
            chk("rnd_pend",  32'(csr_pending), 32'(m_held || m_out));
            chk("rnd_req",   32'(csr_if.func_csr_req_valid),
                32'(m_held && !csr_if.func_csr_ack_busy && !stage_id_clear));
            chk("rnd_wb",    32'(wb_valid), 32'(m_wb));
            chk("rnd_rd",    32'(wb_rd), 32'(m_rd));
            chk("rnd_data",  wb_data, m_data);
            chk("rnd_terr",  32'(timeout_err), 32'(m_terr));
            if (m_held) begin
                chk("rnd_para", 32'(csr_if.func_csr_req_para), 32'(h_para));
                chk("rnd_imm",  32'(csr_if.func_csr_req_imm), 32'(h_imm));
                chk("rnd_pc",   csr_if.func_csr_req_pc, h_pc);
                chk("rnd_op0",  csr_if.func_csr_req_operand0, h_op0);
                chk("rnd_op1",  csr_if.func_csr_req_operand1, h_op1);
            end
            model_step();
            next_cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
